// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and main memory port signal bundle for mem_port_arbiter
//
// Purpose: groups the two requester ports, the shared response, the status
// outputs and the main memory port into one bundle.
// Modports:
//   slave  - the arbiter: samples requests and memory status, drives acks,
//            response, grant/busy and the memory command outputs.
//   master - the surrounding environment (opcode units plus memory).
// Signals:
//   req{0,1}_valid/write/address/width/wdata  requester commands
//   req{0,1}_ack, resp_data, resp_err           completion
//   grant_id, busy                              status
//   address_main, width_main, read_request_main,
//   write_request_main, write_data_main         to memory
//   data_main, busy_main                        from memory

interface mem_port_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int WIDTH_BITS = 2
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [XLEN-1:0]       req0_address;
    logic [WIDTH_BITS-1:0] req0_width;
    logic [XLEN-1:0]       req0_wdata;
    logic                  req1_valid;
    logic                  req1_write;
    logic [XLEN-1:0]       req1_address;
    logic [WIDTH_BITS-1:0] req1_width;
    logic [XLEN-1:0]       req1_wdata;

    logic                  req0_ack;
    logic                  req1_ack;
    logic [XLEN-1:0]       resp_data;
    logic                  resp_err;
    logic                  grant_id;
    logic                  busy;

    logic [XLEN-1:0]       address_main;
    logic [WIDTH_BITS-1:0] width_main;
    logic                  read_request_main;
    logic                  write_request_main;
    logic [XLEN-1:0]       write_data_main;
    logic [XLEN-1:0]       data_main;
    logic                  busy_main;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_width, req0_wdata,
        input  req1_valid, req1_write, req1_address, req1_width, req1_wdata,
        output req0_ack, req1_ack, resp_data, resp_err, grant_id, busy,
        output address_main, width_main, read_request_main, write_request_main,
        output write_data_main,
        input  data_main, busy_main
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_width, req0_wdata,
        output req1_valid, req1_write, req1_address, req1_width, req1_wdata,
        input  req0_ack, req1_ack, resp_data, resp_err, grant_id, busy,
        input  address_main, width_main, read_request_main, write_request_main,
        input  write_data_main,
        output data_main, busy_main
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter for the single main memory port
//
// Purpose: grants the load unit (port 0) or the store unit (port 1) access to
// main memory, issues a one-cycle read/write pulse, follows busy_main to
// completion (with a timeout), and returns data/error with a one-cycle ack.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - mem_port_arbiter_if.slave: requests, response, status, memory port
// All outputs are registered.

module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int WIDTH_BITS = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int                    CNT_W      = $clog2(TIMEOUT);
    localparam logic [WIDTH_BITS-1:0] WIDTH_RSVD = WIDTH_BITS'(3);
    localparam logic [CNT_W-1:0]      WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_id_q, grant_id_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]       address_q, address_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  rd_req_q, rd_req_d;
    logic                  wr_req_q, wr_req_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [XLEN-1:0]       resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  busy_q, busy_d;

    // Arbitration: a lone requester wins outright; on a tie the port that
    // did not win last time gets the memory.
    logic                  any_req;
    logic                  pick1;
    logic                  win_write;
    logic [XLEN-1:0]       win_address;
    logic [WIDTH_BITS-1:0] win_width;
    logic [XLEN-1:0]       win_wdata;
    logic                  win_rsvd;

    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            pick1 = ~last_grant_q;
        end else begin
            pick1 = bus.req1_valid;
        end
        win_write   = pick1 ? bus.req1_write   : bus.req0_write;
        win_address = pick1 ? bus.req1_address : bus.req0_address;
        win_width   = pick1 ? bus.req1_width   : bus.req0_width;
        win_wdata   = pick1 ? bus.req1_wdata   : bus.req0_wdata;
        win_rsvd    = (win_width == WIDTH_RSVD);
    end

    // WAIT exit conditions. A low busy_main in the first WAIT cycle means the
    // memory has not started yet, so completion needs wait_cnt >= 1.
    logic wait_timeout;
    logic wait_exit;

    always_comb begin
        wait_timeout = bus.busy_main && (wait_cnt_q == WAIT_LAST);
        wait_exit    = wait_timeout || (!bus.busy_main && (wait_cnt_q != '0));
    end

    // State register and all output/datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            wait_cnt_q   <= '0;
            address_q    <= '0;
            width_q      <= '0;
            wdata_q      <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cmd_write_q  <= cmd_write_d;
            wait_cnt_q   <= wait_cnt_d;
            address_q    <= address_d;
            width_q      <= width_d;
            wdata_q      <= wdata_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = win_rsvd ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_exit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. Outputs are registered, so each value is prepared on the
    // transition into the state in which it must be visible.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cmd_write_d  = cmd_write_q;
        wait_cnt_d   = wait_cnt_q;
        address_d    = address_q;
        width_d      = width_q;
        wdata_d      = wdata_q;
        rd_req_d     = 1'b0;
        wr_req_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        busy_d       = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (any_req) begin
                    grant_id_d   = pick1;
                    last_grant_d = pick1;
                    cmd_write_d  = win_write;
                    if (win_rsvd) begin
                        // Reserved size: complete with an error, memory untouched.
                        ack0_d     = ~pick1;
                        ack1_d     = pick1;
                        resp_err_d = 1'b1;
                    end else begin
                        address_d = win_address;
                        width_d   = win_width;
                        wdata_d   = win_write ? win_wdata : '0;
                        rd_req_d  = ~win_write;
                        wr_req_d  = win_write;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (wait_exit) begin
                    address_d = '0;
                    width_d   = '0;
                    wdata_d   = '0;
                    ack0_d    = ~grant_id_q;
                    ack1_d    = grant_id_q;
                    if (wait_timeout) begin
                        resp_err_d = 1'b1;
                    end else if (!cmd_write_q) begin
                        resp_data_d = bus.data_main;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                address_d = '0;
                width_d   = '0;
                wdata_d   = '0;
            end
            default: begin
                address_d = '0;
                width_d   = '0;
                wdata_d   = '0;
            end
        endcase
    end

    assign bus.req0_ack           = ack0_q;
    assign bus.req1_ack           = ack1_q;
    assign bus.resp_data          = resp_data_q;
    assign bus.resp_err           = resp_err_q;
    assign bus.grant_id           = grant_id_q;
    assign bus.busy               = busy_q;
    assign bus.address_main       = address_q;
    assign bus.width_main         = width_q;
    assign bus.read_request_main  = rd_req_q;
    assign bus.write_request_main = wr_req_q;
    assign bus.write_data_main    = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int TB_XLEN    = 32;
    localparam int TB_WBITS   = 2;
    localparam int TB_TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(TB_XLEN), .WIDTH_BITS(TB_WBITS)) bus ();

    mem_port_arbiter #(
        .XLEN       (TB_XLEN),
        .WIDTH_BITS (TB_WBITS),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last;

    // Memory model: on a request pulse it stays busy for mem_lat samples
    // (or forever while mem_stuck) and presents mem_rdata.
    int          mem_lat   = 0;
    bit          mem_stuck = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          busy_left = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_left     = 0;
            bus.busy_main = 1'b0;
        end else if (bus.read_request_main || bus.write_request_main) begin
            busy_left     = mem_lat;
            bus.data_main = mem_rdata;
            bus.busy_main = (busy_left > 0) || mem_stuck;
        end else begin
            if (busy_left > 0) busy_left = busy_left - 1;
            bus.busy_main = (busy_left > 0) || mem_stuck;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input bit wr, input logic [31:0] a,
                           input logic [1:0] wd, input logic [31:0] d);
        if (p == 0) begin
            bus.req0_write = wr; bus.req0_address = a; bus.req0_width = wd;
            bus.req0_wdata = d;  bus.req0_valid = 1'b1;
        end else begin
            bus.req1_write = wr; bus.req1_address = a; bus.req1_width = wd;
            bus.req1_wdata = d;  bus.req1_valid = 1'b1;
        end
    endtask

    // Reference rules: reserved size completes at once with an error;
    // otherwise the count of busy WAIT samples decides success or timeout,
    // and WAIT lasts at least 2 cycles. Ack arrives WAIT cycles + 2 after IDLE.
    function automatic void predict(input bit wr, input logic [1:0] wd, input logic [31:0] rdata,
                                    input int lat, input bit stuck,
                                    output logic [31:0] d, output bit e, output int cyc);
        int lw;
        int wc;
        if (wd == 2'd3) begin
            d = '0; e = 1'b1; cyc = 1;
            return;
        end
        lw = stuck ? 1000 : ((lat > 0) ? lat - 1 : 0);
        if (lw >= TB_TIMEOUT) begin
            e = 1'b1; wc = TB_TIMEOUT;
        end else begin
            e = 1'b0; wc = (lw + 1 < 2) ? 2 : lw + 1;
        end
        d   = (e || wr) ? 32'h0 : rdata;
        cyc = wc + 2;
    endfunction

    // Serve one transaction expected on port p, observing the memory side and the ack.
    task automatic serve(input int p, input bit wr, input logic [31:0] addr, input logic [1:0] wd,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                         input bit stuck, input logic [31:0] exp_data, input bit exp_err,
                         input int exp_cyc, input string tag);
        int          pulses;
        bit          got;
        int          cyc;
        bit          p_wr;
        logic [31:0] p_addr, p_wdata, a_data, a_addr;
        logic [1:0]  p_wd;
        bit          a_port, a_err, a_gid;
        bit          bad_both, bad_resp, bad_hold;
        mem_rdata = rdata; mem_lat = lat; mem_stuck = stuck;
        pulses = 0; got = 0; cyc = 0; p_wr = 0; p_addr = 0; p_wdata = 0; p_wd = 0;
        a_data = 0; a_addr = 0; a_port = 0; a_err = 0; a_gid = 0;
        bad_both = 0; bad_resp = 0; bad_hold = 0;
        for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
        chk({tag, " idle_reached"}, bus.busy, 0);
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (bus.req0_ack && bus.req1_ack) bad_both = 1;
            if (!bus.req0_ack && !bus.req1_ack && (bus.resp_data != 0 || bus.resp_err)) bad_resp = 1;
            if (bus.read_request_main || bus.write_request_main) begin
                pulses++;
                if (bus.read_request_main && bus.write_request_main) bad_both = 1;
                p_wr = bus.write_request_main; p_addr = bus.address_main;
                p_wd = bus.width_main;         p_wdata = bus.write_data_main;
            end else if (pulses > 0 && !bus.req0_ack && !bus.req1_ack &&
                         (bus.address_main != p_addr || bus.width_main != p_wd ||
                          bus.write_data_main != p_wdata)) begin
                bad_hold = 1;
            end
            if (bus.req0_ack || bus.req1_ack) begin
                got = 1; cyc = c; a_port = bus.req1_ack; a_data = bus.resp_data;
                a_err = bus.resp_err; a_gid = bus.grant_id; a_addr = bus.address_main;
                if (bus.req1_ack) bus.req1_valid = 1'b0;
                else              bus.req0_valid = 1'b0;
            end
        end
        chk({tag, " ack_seen"}, got, 1);
        chk({tag, " ack_port"}, a_port, p);
        chk({tag, " ack_cycles"}, cyc, exp_cyc);
        chk({tag, " resp_data"}, a_data, exp_data);
        chk({tag, " resp_err"}, a_err, exp_err);
        chk({tag, " grant_id"}, a_gid, p);
        chk({tag, " mem_addr_cleared"}, a_addr, 0);
        chk({tag, " pulses"}, pulses, (wd == 2'd3) ? 0 : 1);
        chk({tag, " protocol"}, {bad_both, bad_resp, bad_hold}, 0);
        if (pulses > 0 && wd != 2'd3) begin
            chk({tag, " pulse_kind"}, p_wr, wr);
            chk({tag, " pulse_addr"}, p_addr, addr);
            chk({tag, " pulse_width"}, p_wd, wd);
            chk({tag, " pulse_wdata"}, p_wdata, wr ? wdata : 32'h0);
        end
        model_last = (p != 0);
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        bit          stuck;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 32'h100, 2'd2, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 1'b0, 5};
        vecs[1] = '{1, 1'b1, 32'h20,  2'd0, 32'hAB,       32'h12345678, 2, 1'b0, 32'h0,        1'b0, 4};
        vecs[2] = '{0, 1'b0, 32'h44,  2'd3, 32'h0,        32'h55555555, 2, 1'b0, 32'h0,        1'b1, 1};
        vecs[3] = '{0, 1'b0, 32'h200, 2'd2, 32'h0,        32'h99999999, 0, 1'b1, 32'h0,        1'b1, 10};
        vecs[4] = '{1, 1'b0, 32'h300, 2'd1, 32'h0,        32'hCAFE0001, 1, 1'b0, 32'hCAFE0001, 1'b0, 4};
        vecs[5] = '{0, 1'b0, 32'h8,   2'd0, 32'h0,        32'h00000011, 0, 1'b0, 32'h00000011, 1'b0, 4};
        vecs[6] = '{1, 1'b0, 32'h40C, 2'd2, 32'h0,        32'h77777777, 8, 1'b0, 32'h77777777, 1'b0, 10};
        vecs[7] = '{0, 1'b0, 32'h410, 2'd2, 32'h0,        32'h88888888, 9, 1'b0, 32'h0,        1'b1, 10};
        vecs[8] = '{0, 1'b1, 32'h500, 2'd2, 32'hFFFF0000, 32'h0,        5, 1'b0, 32'h0,        1'b0, 7};

        reset_n = 1'b0;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_address = 0; bus.req0_width = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_address = 0; bus.req1_width = 0; bus.req1_wdata = 0;
        bus.data_main = 0; bus.busy_main = 0;
        model_last = 1'b1;

        // Reset state, with both ports already requesting.
        set_req(0, 1'b0, 32'h400, 2'd2, 32'h0);
        set_req(1, 1'b0, 32'h480, 2'd2, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {bus.req0_ack, bus.req1_ack, bus.resp_err, bus.grant_id, bus.busy,
                           bus.read_request_main, bus.write_request_main, bus.width_main}, 0);
        chk("reset_data", bus.address_main | bus.resp_data | bus.write_data_main, 0);
        reset_n = 1'b1;

        // Contention from reset: port 0, then port 1, then port 0 again on the next tie.
        serve(0, 1'b0, 32'h400, 2'd2, 32'h0, 32'h11110000, 2, 1'b0, 32'h11110000, 1'b0, 4, "t2_a0");
        serve(1, 1'b0, 32'h480, 2'd2, 32'h0, 32'h22220000, 2, 1'b0, 32'h22220000, 1'b0, 4, "t2_a1");
        set_req(0, 1'b0, 32'h404, 2'd1, 32'h0);
        set_req(1, 1'b1, 32'h484, 2'd2, 32'h1234);
        serve(0, 1'b0, 32'h404, 2'd1, 32'h0, 32'h33330000, 3, 1'b0, 32'h33330000, 1'b0, 5, "t2_b0");
        serve(1, 1'b1, 32'h484, 2'd2, 32'h1234, 32'h0, 2, 1'b0, 32'h0, 1'b0, 4, "t2_b1");

        // Table of single-port transactions.
        for (int i = 0; i < 9; i++) begin
            set_req(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].width, vecs[i].wdata);
            serve(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].width, vecs[i].wdata,
                  vecs[i].rdata, vecs[i].lat, vecs[i].stuck, vecs[i].exp_data,
                  vecs[i].exp_err, vecs[i].exp_cyc, $sformatf("vec%0d", i));
        end

        // Reset in the middle of WAIT: everything clears at once, no ack,
        // and the still-pending port 1 request is served afterwards.
        begin
            bit pulse_seen;
            bit ack_in_reset;
            pulse_seen = 0; ack_in_reset = 0;
            for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
            mem_stuck = 1'b1; mem_lat = 0;
            set_req(1, 1'b0, 32'h600, 2'd2, 32'h0);
            for (int k = 0; k < 10 && !pulse_seen; k++) begin
                @(negedge clk);
                if (bus.read_request_main) pulse_seen = 1;
            end
            chk("t6_pulse_seen", pulse_seen, 1);
            repeat (2) @(negedge clk);
            #2 reset_n = 1'b0;
            #1;
            chk("t6_ctrl_cleared", {bus.req0_ack, bus.req1_ack, bus.resp_err, bus.grant_id, bus.busy,
                                    bus.read_request_main, bus.write_request_main, bus.width_main}, 0);
            chk("t6_data_cleared", bus.address_main | bus.resp_data | bus.write_data_main, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus.req0_ack || bus.req1_ack) ack_in_reset = 1;
            end
            chk("t6_no_ack", ack_in_reset, 0);
            reset_n = 1'b1;
            model_last = 1'b1;
            serve(1, 1'b0, 32'h600, 2'd2, 32'h0, 32'h66666666, 3, 1'b0, 32'h66666666, 1'b0, 5, "t6_after");
        end

        // Randomized traffic against the reference rules.
        for (int it = 0; it < 40; it++) begin
            bit          v0, v1;
            bit          w[2];
            logic [31:0] a[2], d[2], rd[2];
            logic [1:0]  wd[2];
            int          lt[2];
            bit          st[2];
            int          first, other;
            logic [31:0] ed;
            bit          ee;
            int          ec;
            v0 = bit'($urandom_range(0, 1));
            v1 = bit'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            for (int p = 0; p < 2; p++) begin
                w[p]  = bit'($urandom_range(0, 1));
                a[p]  = $urandom;
                d[p]  = $urandom;
                rd[p] = $urandom;
                wd[p] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                lt[p] = $urandom_range(0, 12);
                st[p] = ($urandom_range(0, 9) == 0);
            end
            for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
            if (v0) set_req(0, w[0], a[0], wd[0], d[0]);
            if (v1) set_req(1, w[1], a[1], wd[1], d[1]);
            first = (v0 && v1) ? (model_last ? 0 : 1) : (v1 ? 1 : 0);
            predict(w[first], wd[first], rd[first], lt[first], st[first], ed, ee, ec);
            serve(first, w[first], a[first], wd[first], d[first], rd[first], lt[first], st[first],
                  ed, ee, ec, $sformatf("rnd%0d_p%0d", it, first));
            if (v0 && v1) begin
                other = 1 - first;
                predict(w[other], wd[other], rd[other], lt[other], st[other], ed, ee, ec);
                serve(other, w[other], a[other], wd[other], d[other], rd[other], lt[other], st[other],
                      ed, ee, ec, $sformatf("rnd%0d_p%0d", it, other));
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
